// File: rtl/oled_pkg.sv
// oled_pkg: shared types and constants for the SSD1306 I2C byte transmitter.
// Holds the transmitter FSM state enum, the SSD1306 control-byte values,
// the default bus address and the width of the quarter-bit divider.
package oled_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_ADDR  = 3'd2,
        ST_CTRL  = 3'd3,
        ST_DATA  = 3'd4,
        ST_STOP  = 3'd5
    } oled_state_e;

    // SSD1306 control bytes: Co=0, D/C#=0 for commands, D/C#=1 for GDDRAM data
    localparam logic [7:0] OLED_CTRL_CMD  = 8'h00;
    localparam logic [7:0] OLED_CTRL_DATA = 8'h40;

    // SSD1306 7-bit address with SA0 tied low
    localparam logic [6:0] OLED_DEFAULT_ADDR = 7'h3C;

    // Divider is wide enough for the largest legal CLK_DIV of 1023
    localparam int unsigned OLED_DIV_W = 10;

    // Bit slots 0..7 carry the byte MSB first, slot 8 is the ACK slot
    localparam logic [3:0] OLED_ACK_SLOT = 4'd8;

    // Pick the control byte that tells the panel what the next byte is
    function automatic logic [7:0] oled_ctrl_byte(input logic dcn);
        return dcn ? OLED_CTRL_DATA : OLED_CTRL_CMD;
    endfunction

endpackage

// File: rtl/oled_i2c_tick.sv
// oled_i2c_tick: quarter-bit divider for the OLED I2C transmitter.
// While run is high it counts CLK_DIV clock cycles per phase and raises tick
// for exactly one cycle at the last cycle of every phase; the counter then
// reloads to zero. Dropping run parks the counter at zero, so the first phase
// after run rises is always a full CLK_DIV cycles long.
module oled_i2c_tick
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV = 120
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [OLED_DIV_W-1:0] LAST = OLED_DIV_W'(CLK_DIV - 1);

    logic [OLED_DIV_W-1:0] count;

    // Count cycles within a phase, reloading at every phase boundary
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + OLED_DIV_W'(1);
        end
    end

    assign tick = run && (count == LAST);

endmodule

// File: rtl/oled_i2c_tx.sv
// oled_i2c_tx: write-only I2C master that sends one byte to an SSD1306 OLED.
// Each request produces START, address+W, control byte (command or data),
// the payload byte and STOP. Every slot is split into four phases of CLK_DIV
// cycles; scl/sda are registered and computed from the next FSM position so
// they change exactly on phase boundaries.
// Optional feature macro: OLED_I2C_NACK_CHECK_EN adds sda_in/nack and aborts
// the frame with a STOP when an ACK slot reads back high.
module oled_i2c_tx
    import oled_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 120,
    parameter logic [6:0]  SLAVE_ADDR = OLED_DEFAULT_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       DCn,
    input  logic [7:0] Data,
`ifdef OLED_I2C_NACK_CHECK_EN
    input  logic       sda_in,
    output logic       nack,
`endif
    output logic       busy,
    output logic       scl,
    output logic       sda
);

    oled_state_e state;
    oled_state_e state_n;
    logic [1:0]  phase;
    logic [1:0]  phase_n;
    logic [3:0]  bit_idx;
    logic [3:0]  bit_n;
    logic [7:0]  data_q;
    logic        dcn_q;
    logic [7:0]  cur_byte;
    logic        scl_n;
    logic        sda_n;
    logic        tick;
    logic        nack_hit;
    logic        accept;

    // A request is only taken while idle; anything during a frame is dropped
    assign accept = (state == ST_IDLE) && start;

    oled_i2c_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (state != ST_IDLE),
        .tick (tick)
    );

`ifdef OLED_I2C_NACK_CHECK_EN
    logic nack_seen;

    // Sample the slave's ACK late in the high half of the ACK slot and pulse nack as busy drops
    always_ff @(posedge clk) begin
        if (rst) begin
            nack_seen <= 1'b0;
            nack      <= 1'b0;
        end else begin
            nack <= 1'b0;
            if (accept) begin
                nack_seen <= 1'b0;
            end else if (tick && (phase == 2'd2) && (bit_idx == OLED_ACK_SLOT) &&
                         ((state == ST_ADDR) || (state == ST_CTRL) || (state == ST_DATA))) begin
                nack_seen <= sda_in;
            end
            if ((state == ST_STOP) && tick && (phase == 2'd3)) begin
                nack <= nack_seen;
            end
        end
    end

    assign nack_hit = nack_seen;
`else
    assign nack_hit = 1'b0;
`endif

    // Advance phase / bit slot / state on every phase strobe
    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        if (state == ST_IDLE) begin
            if (start) begin
                state_n = ST_START;
                phase_n = 2'd0;
                bit_n   = 4'd0;
            end
        end else if (tick) begin
            phase_n = phase + 2'd1;
            if (phase == 2'd3) begin
                case (state)
                    ST_START: begin
                        state_n = ST_ADDR;
                        bit_n   = 4'd0;
                    end
                    ST_ADDR: begin
                        if (bit_idx == OLED_ACK_SLOT) begin
                            bit_n   = 4'd0;
                            state_n = nack_hit ? ST_STOP : ST_CTRL;
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end
                    ST_CTRL: begin
                        if (bit_idx == OLED_ACK_SLOT) begin
                            bit_n   = 4'd0;
                            state_n = nack_hit ? ST_STOP : ST_DATA;
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_idx == OLED_ACK_SLOT) begin
                            bit_n   = 4'd0;
                            state_n = ST_STOP;
                        end else begin
                            bit_n = bit_idx + 4'd1;
                        end
                    end
                    ST_STOP: begin
                        state_n = ST_IDLE;
                    end
                    default: begin
                        state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Select the byte that is being shifted out in the upcoming byte state
    always_comb begin
        cur_byte = 8'hFF;
        case (state_n)
            ST_ADDR: cur_byte = {SLAVE_ADDR, 1'b0};
            ST_CTRL: cur_byte = oled_ctrl_byte(dcn_q);
            ST_DATA: cur_byte = data_q;
            default: cur_byte = 8'hFF;
        endcase
    end

    // Decode the upcoming slot/phase into bus levels; sda only moves while scl is low
    always_comb begin
        scl_n = 1'b1;
        sda_n = 1'b1;
        case (state_n)
            ST_START: begin
                scl_n = (phase_n != 2'd3);
                sda_n = (phase_n < 2'd2);
            end
            ST_ADDR, ST_CTRL, ST_DATA: begin
                scl_n = phase_n[1];
                if (bit_n == OLED_ACK_SLOT) begin
                    sda_n = 1'b1;
                end else begin
                    sda_n = cur_byte[3'd7 - bit_n[2:0]];
                end
            end
            ST_STOP: begin
                scl_n = (phase_n != 2'd0);
                sda_n = phase_n[1];
            end
            default: begin
                scl_n = 1'b1;
                sda_n = 1'b1;
            end
        endcase
    end

    // Register FSM position, captured request and bus outputs; reset releases the bus at once
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            phase   <= 2'd0;
            bit_idx <= 4'd0;
            data_q  <= 8'h00;
            dcn_q   <= 1'b0;
            busy    <= 1'b0;
            scl     <= 1'b1;
            sda     <= 1'b1;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_idx <= bit_n;
            busy    <= (state_n != ST_IDLE);
            scl     <= scl_n;
            sda     <= sda_n;
            if (accept) begin
                data_q <= Data;
                dcn_q  <= DCn;
            end
        end
    end

endmodule

// File: tb/tb_oled_i2c_tx.sv
// tb_oled_i2c_tx: self-checking bench for oled_i2c_tx with CLK_DIV=4.
// A bus decoder turns scl/sda back into START/STOP events and bytes, and a
// cycle-offset waveform model predicts scl/sda for every cycle of a frame.
// With OLED_I2C_NACK_CHECK_EN defined, the NACK abort path is also exercised.
module tb_oled_i2c_tx;

    localparam int unsigned DIV       = 4;
    localparam int          FRAME_LEN = 116 * DIV;
    localparam logic [6:0]  ADDR      = 7'h3C;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       DCn;
    logic [7:0] Data;
    logic       busy;
    logic       scl;
    logic       sda;
`ifdef OLED_I2C_NACK_CHECK_EN
    logic       sda_in;
    logic       nack;
    int         n_nack = 0;
`endif

    int errors = 0;
    int checks = 0;

    oled_i2c_tx #(
        .CLK_DIV    (DIV),
        .SLAVE_ADDR (ADDR)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .DCn    (DCn),
        .Data   (Data),
`ifdef OLED_I2C_NACK_CHECK_EN
        .sda_in (sda_in),
        .nack   (nack),
`endif
        .busy   (busy),
        .scl    (scl),
        .sda    (sda)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Bus decoder: START/STOP detection, bit capture on scl rise, sda-stable checker
    logic       prev_scl = 1'b1;
    logic       prev_sda = 1'b1;
    int         n_start  = 0;
    int         n_stop   = 0;
    int         n_viol   = 0;
    int         bit_cnt  = 0;
    logic [8:0] shreg    = '0;
    logic [7:0] got_q[$];

    always @(negedge clk) begin
        if (prev_scl && scl && prev_sda && !sda) begin
            n_start = n_start + 1;
            bit_cnt = 0;
        end else if (prev_scl && scl && !prev_sda && sda) begin
            n_stop = n_stop + 1;
        end else if (!prev_scl && scl) begin
            if (prev_sda != sda) n_viol = n_viol + 1;
            shreg   = {shreg[7:0], sda};
            bit_cnt = bit_cnt + 1;
            if (bit_cnt == 9) begin
                got_q.push_back(shreg[8:1]);
                bit_cnt = 0;
            end
        end
        prev_scl = scl;
        prev_sda = sda;
`ifdef OLED_I2C_NACK_CHECK_EN
        if (nack) n_nack = n_nack + 1;
`endif
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [7:0] ref_ctrl(input logic dcn);
        return dcn ? 8'h40 : 8'h00;
    endfunction

    // Expected {scl,sda} at cycle offset k from the first busy cycle of a full frame
    function automatic logic [1:0] exp_bus(input int k, input logic [7:0] d, input logic dcn);
        int         slot;
        int         ph;
        int         b;
        logic [7:0] bytes [3];
        logic [7:0] cur;
        logic       s;
        slot  = k / (4 * DIV);
        ph    = (k / DIV) % 4;
        bytes = '{{ADDR, 1'b0}, ref_ctrl(dcn), d};
        if (slot == 0) return {(ph != 3), (ph < 2)};
        if (slot <= 27) begin
            b   = slot - 1;
            cur = bytes[b / 9];
            s   = ((b % 9) == 8) ? 1'b1 : cur[7 - (b % 9)];
            return {(ph >= 2), s};
        end
        if (slot == 28) return {(ph != 0), (ph >= 2)};
        return 2'b11;
    endfunction

    task automatic applyStimulus(input logic [7:0] d, input logic dcn);
        @(posedge clk);
        #1;
        start = 1'b1;
        Data  = d;
        DCn   = dcn;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follow one frame cycle by cycle; optionally poke a stray start at offset poke_at
    task automatic run_frame(input logic [7:0] d, input logic dcn, input int poke_at,
                             output int len, output int wave_err);
        len      = 0;
        wave_err = 0;
        for (int k = 0; k < FRAME_LEN + 50; k++) begin
            @(negedge clk);
            if (!busy) break;
            if ({scl, sda} != exp_bus(k, d, dcn)) wave_err = wave_err + 1;
            if (k == poke_at) begin
                start = 1'b1;
                Data  = ~d;
                DCn   = ~dcn;
            end else begin
                start = 1'b0;
            end
            len = len + 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] d, input logic dcn,
                               input int len, input int wave_err,
                               input int s0, input int p0, input int v0, input int q0);
        check({tag, " busy length"}, len, FRAME_LEN);
        check({tag, " waveform errors"}, wave_err, 0);
        check({tag, " start count"}, n_start - s0, 1);
        check({tag, " stop count"}, n_stop - p0, 1);
        check({tag, " sda change at scl rise"}, n_viol - v0, 0);
        check({tag, " byte count"}, got_q.size() - q0, 3);
        if (got_q.size() - q0 == 3) begin
            check({tag, " addr byte"}, got_q[q0], {ADDR, 1'b0});
            check({tag, " ctrl byte"}, got_q[q0 + 1], ref_ctrl(dcn));
            check({tag, " data byte"}, got_q[q0 + 2], d);
        end
        check({tag, " idle bus"}, {scl, sda}, 2'b11);
    endtask

    typedef struct {
        logic [7:0] d;
        logic       dcn;
        logic [7:0] exp_ctrl;
        int         exp_len;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int len;
        int werr;
        int s0, p0, v0, q0;
        logic [7:0] rd;
        logic       rdcn;

        vecs[0] = '{8'hAF, 1'b0, 8'h00, 464};
        vecs[1] = '{8'h5A, 1'b1, 8'h40, 464};
        vecs[2] = '{8'h00, 1'b0, 8'h00, 464};
        vecs[3] = '{8'hFF, 1'b1, 8'h40, 464};

        rst   = 1'b1;
        start = 1'b0;
        DCn   = 1'b0;
        Data  = 8'h00;
`ifdef OLED_I2C_NACK_CHECK_EN
        sda_in = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset scl", scl, 1);
        check("reset sda", sda, 1);
        rst = 1'b0;

        // Table-driven frames
        for (int i = 0; i < 4; i++) begin
            s0 = n_start; p0 = n_stop; v0 = n_viol; q0 = got_q.size();
            applyStimulus(vecs[i].d, vecs[i].dcn);
            run_frame(vecs[i].d, vecs[i].dcn, -1, len, werr);
            check($sformatf("vec%0d length", i), len, vecs[i].exp_len);
            if (got_q.size() - q0 == 3)
                check($sformatf("vec%0d ctrl", i), got_q[q0 + 1], vecs[i].exp_ctrl);
            checkOutput($sformatf("vec%0d", i), vecs[i].d, vecs[i].dcn, len, werr, s0, p0, v0, q0);
        end

        // Randomized frames against the reference model
        for (int i = 0; i < 4; i++) begin
            rd   = 8'($urandom);
            rdcn = 1'($urandom_range(0, 1));
            s0 = n_start; p0 = n_stop; v0 = n_viol; q0 = got_q.size();
            applyStimulus(rd, rdcn);
            run_frame(rd, rdcn, -1, len, werr);
            checkOutput($sformatf("rand%0d", i), rd, rdcn, len, werr, s0, p0, v0, q0);
        end

        // Stray start 10 cycles in, then back-to-back start on the busy-fall cycle
        s0 = n_start; p0 = n_stop; v0 = n_viol; q0 = got_q.size();
        applyStimulus(8'h96, 1'b0);
        run_frame(8'h96, 1'b0, 10, len, werr);
        checkOutput("ignored start", 8'h96, 1'b0, len, werr, s0, p0, v0, q0);
        s0 = n_start; p0 = n_stop; v0 = n_viol; q0 = got_q.size();
        start = 1'b1;
        Data  = 8'hC3;
        DCn   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        run_frame(8'hC3, 1'b1, -1, len, werr);
        checkOutput("back-to-back", 8'hC3, 1'b1, len, werr, s0, p0, v0, q0);

        // Reset 200 cycles into a frame aborts immediately
        applyStimulus(8'h00, 1'b1);
        repeat (200) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort busy", busy, 0);
        check("abort scl", scl, 1);
        check("abort sda", sda, 1);
        rst = 1'b0;
        @(negedge clk);
        s0 = n_start; p0 = n_stop; v0 = n_viol; q0 = got_q.size();
        applyStimulus(8'h81, 1'b0);
        run_frame(8'h81, 1'b0, -1, len, werr);
        checkOutput("after abort", 8'h81, 1'b0, len, werr, s0, p0, v0, q0);

        // Reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        Data  = 8'h77;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("rst+start busy", busy, 0);
        repeat (3) @(negedge clk);
        check("rst+start stays idle", busy, 0);

`ifdef OLED_I2C_NACK_CHECK_EN
        // Slave NACKs the address: STOP right after the address ACK slot
        begin
            int nk0;
            nk0    = n_nack;
            s0     = n_stop;
            sda_in = 1'b1;
            applyStimulus(8'h12, 1'b0);
            run_frame(8'h12, 1'b0, -1, len, werr);
            check("nack busy length", len, 44 * DIV);
            @(negedge clk);
            sda_in = 1'b0;
            check("nack pulse count", n_nack - nk0, 1);
            check("nack stop count", n_stop - s0, 1);
            check("nack low after pulse", nack, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oled_i2c_tx.md
OLED_I2C_TX -- requirements
Module: oled_i2c_tx

Interface
REQ-001 SHALL have parameter CLK_DIV, default 120, clk cycles per I2C quarter-bit (50 MHz -> ~104 kHz SCL); legal range 2..1023.
REQ-002 SHALL have parameter SLAVE_ADDR, default 7'h3C, 7-bit SSD1306 bus address.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle request to send one byte.
REQ-006 DCn  input  1  0 = command byte, 1 = display-data byte.
REQ-007 Data  input  8  byte to send.
REQ-008 busy  output  1  high while a transaction is in progress.
REQ-009 scl  output  1  I2C serial clock, idles high.
REQ-010 sda  output  1  I2C serial data, idles high.

Function
REQ-011 SHALL, when idle, accept start=1 at a rising edge, capture Data and DCn on that edge, and raise busy on the next cycle.
REQ-012 SHALL ignore start while busy=1; captured Data/DCn are not altered mid-transaction.
REQ-013 SHALL send, per transaction: START, {SLAVE_ADDR,1'b0}, ACK slot, control byte (8'h40 if DCn else 8'h00), ACK slot, Data, ACK slot, STOP; all bytes MSB first.
REQ-014 SHALL use the FSM states IDLE -> START -> ADDR -> CTRL -> DATA -> STOP -> IDLE; each byte state covers 9 bit slots (8 data + ACK).
REQ-015 SHALL split every bit slot and the START/STOP slots into 4 phases of CLK_DIV cycles each, timed by a quarter-bit counter that reloads at every phase boundary.
REQ-016 Bit slot: phases 0-1 scl=0 with sda updated at the start of phase 0; phases 2-3 scl=1; sda=1 (released) for the whole ACK slot.
REQ-017 START slot: phases 0-1 scl=1 sda=1; phase 2 scl=1 sda=0; phase 3 scl=0 sda=0.
REQ-018 STOP slot: phase 0 scl=0 sda=0; phase 1 scl=1 sda=0; phases 2-3 scl=1 sda=1.
REQ-019 SHALL hold sda stable whenever scl=1, except for the START/STOP edges.
REQ-020 Transaction length from first busy=1 cycle to first busy=0 cycle SHALL be exactly 116*CLK_DIV cycles.
REQ-021 SHALL drop busy in the cycle after STOP phase 3 ends; a start in that same idle cycle SHALL be accepted, giving back-to-back transactions with no extra gap.

Reset
REQ-022 With rst=1: state=IDLE, busy=0, scl=1, sda=1, counters=0, captured byte=0 on the next edge.
REQ-023 rst asserted mid-transaction SHALL abort at once without generating STOP; the bus is released to scl=1, sda=1.
REQ-024 rst has priority over a simultaneous start; that request is dropped.

Configuration
REQ-025 Macro OLED_I2C_NACK_CHECK_EN: when defined, adds input sda_in (1 bit) and output nack (1 bit, reset 0).
REQ-026 With the macro, sda_in SHALL be sampled at the end of phase 2 of every ACK slot; if it reads 1, the FSM jumps to STOP, and nack SHALL pulse high for one cycle with busy falling.
REQ-027 Without the macro, ACK slots are not checked, the ports are absent, and every transaction runs to full length.

Structure
REQ-028 Shared package oled_pkg SHALL hold the FSM state enum, the SSD1306 control-byte constants (8'h00, 8'h40), and the default address 7'h3C.
REQ-029 One sub-module, oled_i2c_tick (quarter-bit divider producing a one-cycle phase strobe), is natural; everything else stays flat.

Verification (CLK_DIV=4)
REQ-030 start with Data=8'hAF, DCn=0 -> decoded bits: START, 78, ACK, 00, ACK, AF, ACK, STOP; busy high for 464 cycles.
REQ-031 start with Data=8'h5A, DCn=1 -> control byte decodes 40 and data decodes 5A; an SDA-stable-while-SCL-high checker never fires.
REQ-032 A second start 10 cycles into a transaction -> ignored; exactly one STOP seen; then start on the busy-fall cycle -> second transaction begins the next cycle.
REQ-033 rst pulse at cycle 200 of a transaction -> next cycle scl=1, sda=1, busy=0; a following start sends a complete frame.
REQ-034 With OLED_I2C_NACK_CHECK_EN, sda_in=1 in the address ACK slot -> STOP follows at once, a one-cycle nack pulse occurs, and busy falls 44*CLK_DIV = 176 cycles after rising.
